// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: word-level controller around an overlapping "1101" Mealy detector.
// Shifts each accepted word MSB-first, counts matches and records the first match position.
module pattern_scan_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4,
   parameter int POS_W = 3
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_chain,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [CNT_W-1:0] out_count,
   output logic [POS_W-1:0] out_first,
   output logic             out_found,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, REPORT = 2'd2} ctrl_e;
   typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} det_e;

   ctrl_e            state_r, state_nxt_s;
   det_e             det_r, det_nxt_s;
   logic [WIDTH-1:0] shreg_r;
   logic [IDX_W-1:0] bit_idx_r;
   logic [CNT_W-1:0] count_r;
   logic [POS_W-1:0] first_r;
   logic             found_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             bit_s;
   logic             match_s;
   logic             accept_s;

   // Next-state for the controller and the bit-serial detector; the detector moves only in SHIFT.
   always_comb begin
      state_nxt_s = state_r;
      det_nxt_s   = det_r;
      match_s     = 1'b0;
      accept_s    = 1'b0;
      bit_s       = shreg_r[WIDTH-1];
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               accept_s    = 1'b1;
               state_nxt_s = SHIFT;
               if (!in_chain) begin
                  det_nxt_s = S0;
               end else begin
                  det_nxt_s = det_r;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            case (det_r)
               S0:      det_nxt_s = bit_s ? S1 : S0;
               S1:      det_nxt_s = bit_s ? S2 : S0;
               S2:      det_nxt_s = bit_s ? S2 : S3;
               S3: begin
                  if (bit_s) begin
                     match_s   = 1'b1;
                     det_nxt_s = S1;
                  end else begin
                     det_nxt_s = S0;
                  end
               end
               default: det_nxt_s = S0;
            endcase
            if (bit_idx_r == LAST_IDX) begin
               state_nxt_s = REPORT;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         REPORT: begin
            if (out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = REPORT;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, handshake flags and per-word result registers; handshake flags follow the next state.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_r     <= IDLE;
         det_r       <= S0;
         shreg_r     <= {WIDTH{1'b0}};
         bit_idx_r   <= {IDX_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         first_r     <= {POS_W{1'b0}};
         found_r     <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         det_r       <= det_nxt_s;
         in_ready_r  <= (state_nxt_s == IDLE);
         out_valid_r <= (state_nxt_s == REPORT);
         if (accept_s) begin
            shreg_r   <= in_data;
            bit_idx_r <= {IDX_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            first_r   <= {POS_W{1'b0}};
            found_r   <= 1'b0;
         end else if (state_r == SHIFT) begin
            shreg_r   <= {shreg_r[WIDTH-2:0], 1'b0};
            bit_idx_r <= bit_idx_r + IDX_W'(1);
            if (match_s) begin
               if (count_r != CNT_MAX) begin
                  count_r <= count_r + CNT_W'(1);
               end else begin
                  count_r <= count_r;
               end
               if (!found_r) begin
                  first_r <= POS_W'(bit_idx_r);
                  found_r <= 1'b1;
               end else begin
                  found_r <= found_r;
               end
            end else begin
               count_r <= count_r;
            end
         end else begin
            shreg_r <= shreg_r;
         end
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_count = count_r;
   assign out_first = first_r;
   assign out_found = found_r;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed and reference-model bench for pattern_scan_ctrl (8-bit default and a 32-bit instance).
module tb_pattern_scan_ctrl;
   logic        Clock = 1'b0;
   logic        Reset;
   logic [7:0]  in_data;
   logic        in_chain, in_valid, in_ready;
   logic [3:0]  out_count;
   logic [2:0]  out_first;
   logic        out_found, out_valid, out_ready;

   logic [31:0] w_in_data;
   logic        w_in_chain, w_in_valid, w_in_ready;
   logic [2:0]  w_out_count;
   logic [4:0]  w_out_first;
   logic        w_out_found, w_out_valid, w_out_ready;

   int checks = 0;
   int errors = 0;

   always #5 Clock = ~Clock;

   pattern_scan_ctrl dut (
      .Clock(Clock), .Reset(Reset), .in_data(in_data), .in_chain(in_chain),
      .in_valid(in_valid), .in_ready(in_ready), .out_count(out_count),
      .out_first(out_first), .out_found(out_found), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   pattern_scan_ctrl #(.WIDTH(32), .CNT_W(3), .POS_W(5)) dut_w (
      .Clock(Clock), .Reset(Reset), .in_data(w_in_data), .in_chain(w_in_chain),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .out_count(w_out_count),
      .out_first(w_out_first), .out_found(w_out_found), .out_valid(w_out_valid),
      .out_ready(w_out_ready)
   );

   // Offers one word, then counts negedges from the accept edge until out_valid rises.
   task automatic do_word(input logic [7:0] d, input logic ch, output int lat);
      int n = 0;
      while (!in_ready && n < 40) begin
         @(negedge Clock);
         n++;
      end
      in_data  = d;
      in_chain = ch;
      in_valid = 1'b1;
      @(negedge Clock);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge Clock);
         lat++;
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      @(negedge Clock);
      @(negedge Clock);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
      end
      checks++;
      if (out_count !== 4'd0 || out_first !== 3'd0 || out_found !== 1'b0) begin
         errors++;
         $display("FAIL reset_res: count=%0d first=%0d found=%b, expected 0 0 0", out_count, out_first, out_found);
      end
      Reset = 1'b0;
      @(negedge Clock);
   endtask

   task automatic test_basic();
      int lat;
      out_ready = 1'b1;
      do_word(8'b11011011, 1'b0, lat);
      checks++;
      if (lat != 8) begin
         errors++;
         $display("FAIL basic_latency: got %0d, expected 8", lat);
      end
      checks++;
      if (out_count !== 4'd2 || out_first !== 3'd3 || out_found !== 1'b1) begin
         errors++;
         $display("FAIL basic_result: count=%0d first=%0d found=%b, expected 2 3 1", out_count, out_first, out_found);
      end
      @(negedge Clock);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_chain();
      int lat;
      do_word(8'b01000000, 1'b1, lat);
      checks++;
      if (lat != 8 || out_count !== 4'd1 || out_first !== 3'd1 || out_found !== 1'b1) begin
         errors++;
         $display("FAIL chain: lat=%0d count=%0d first=%0d found=%b, expected 8 1 1 1", lat, out_count, out_first, out_found);
      end
      @(negedge Clock);
   endtask

   task automatic test_nochain();
      int lat;
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      do_word(8'b01000000, 1'b0, lat);
      checks++;
      if (lat != 8 || out_count !== 4'd0 || out_first !== 3'd0 || out_found !== 1'b0) begin
         errors++;
         $display("FAIL nochain: lat=%0d count=%0d first=%0d found=%b, expected 8 0 0 0", lat, out_count, out_first, out_found);
      end
      @(negedge Clock);
   endtask

   task automatic test_backpressure();
      int lat;
      logic bad = 1'b0;
      out_ready = 1'b0;
      do_word(8'b10110110, 1'b0, lat);
      checks++;
      if (lat != 8 || out_count !== 4'd1 || out_first !== 3'd5 || out_found !== 1'b1) begin
         errors++;
         $display("FAIL bp_result: lat=%0d count=%0d first=%0d found=%b, expected 8 1 5 1", lat, out_count, out_first, out_found);
      end
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== 4'd1 || out_first !== 3'd5 || out_found !== 1'b1)
            bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL bp_hold: out_valid=%b in_ready=%b count=%0d first=%0d, expected 1 0 1 5", out_valid, in_ready, out_count, out_first);
      end
      out_ready = 1'b1;
      @(negedge Clock);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
      end
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock);
         if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL bp_single: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_shift();
      int lat;
      logic seen = 1'b0;
      out_ready = 1'b1;
      in_data   = 8'hFF;
      in_chain  = 1'b1;
      in_valid  = 1'b1;
      @(negedge Clock);
      in_valid = 1'b0;
      repeat (3) @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_count !== 4'd0 || out_found !== 1'b0) begin
         errors++;
         $display("FAIL midreset_clear: in_ready=%b count=%0d found=%b, expected 1 0 0", in_ready, out_count, out_found);
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge Clock);
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL midreset_novalid: out_valid asserted=%b, expected 0", seen);
      end
      do_word(8'b11010000, 1'b1, lat);
      checks++;
      if (lat != 8 || out_count !== 4'd1 || out_first !== 3'd3 || out_found !== 1'b1) begin
         errors++;
         $display("FAIL midreset_next: lat=%0d count=%0d first=%0d found=%b, expected 8 1 3 1", lat, out_count, out_first, out_found);
      end
      @(negedge Clock);
   endtask

   task automatic test_wide();
      int lat = 0;
      w_out_ready = 1'b1;
      w_in_data   = 32'hDB6DB6DB;
      w_in_chain  = 1'b0;
      w_in_valid  = 1'b1;
      @(negedge Clock);
      w_in_valid = 1'b0;
      while (!w_out_valid && lat < 60) begin
         @(negedge Clock);
         lat++;
      end
      checks++;
      if (lat != 32 || w_out_count !== 3'd7 || w_out_first !== 5'd3 || w_out_found !== 1'b1) begin
         errors++;
         $display("FAIL wide_sat: lat=%0d count=%0d first=%0d found=%b, expected 32 7 3 1", lat, w_out_count, w_out_first, w_out_found);
      end
      @(negedge Clock);
      checks++;
      if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL wide_release: out_valid=%b in_ready=%b, expected 0 1", w_out_valid, w_in_ready);
      end
   endtask

   task automatic test_random();
      logic [2:0] hist = 3'b000;
      logic [7:0] d;
      logic       ch;
      logic [3:0] ecnt;
      logic [2:0] efirst;
      logic       efound;
      int         lat, n;
      int         results = 0;
      for (int w = 0; w < 30; w++) begin
         d  = 8'($urandom);
         ch = (w == 0) ? 1'b0 : 1'($urandom);
         if (!ch) hist = 3'b000;
         ecnt = 4'd0; efirst = 3'd0; efound = 1'b0;
         for (int i = 7; i >= 0; i--) begin
            if ({hist, d[i]} == 4'b1101) begin
               if (ecnt != 4'd15) ecnt = ecnt + 4'd1;
               if (!efound) begin
                  efound = 1'b1;
                  efirst = 3'(7 - i);
               end
            end
            hist = {hist[1:0], d[i]};
         end
         out_ready = 1'($urandom);
         do_word(d, ch, lat);
         checks++;
         if (lat != 8 || out_count !== ecnt || out_first !== efirst || out_found !== efound) begin
            errors++;
            $display("FAIL rand_word%0d: data=%h chain=%b lat=%0d count=%0d first=%0d found=%b, expected 8 %0d %0d %b",
                     w, d, ch, lat, out_count, out_first, out_found, ecnt, efirst, efound);
         end
         n = 0;
         while (out_valid && n < 40) begin
            out_ready = 1'($urandom);
            @(negedge Clock);
            n++;
         end
         if (!out_valid) results++;
      end
      checks++;
      if (results != 30) begin
         errors++;
         $display("FAIL rand_transfers: got %0d, expected 30", results);
      end
   endtask

   initial begin
      Reset       = 1'b1;
      in_data     = 8'd0;
      in_chain    = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      w_in_data   = 32'd0;
      w_in_chain  = 1'b0;
      w_in_valid  = 1'b0;
      w_out_ready = 1'b0;
      @(negedge Clock);
      test_reset();
      test_basic();
      test_chain();
      test_nochain();
      test_backpressure();
      test_reset_mid_shift();
      test_wide();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
